// File: rtl/motor_arbiter_if.sv
// ------------------------------------------------------------------
// motor_arbiter_if : requester / H-bridge signal bundle. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface motor_arbiter_if;
   logic       enable;
   logic       overide;
   logic       turn_req;
   logic [1:0] turn_cmd;
   logic       turn_pwm;
   logic       seek_req;
   logic [1:0] seek_cmd;
   logic       seek_pwm;
   logic       f_IN1;
   logic       f_IN2;
   logic       f_IN3;
   logic       f_IN4;
   logic       f_enA;
   logic       f_enB;
   logic       turn_gnt;
   logic       seek_gnt;
   logic       fault_active;

   modport master (
      output enable, overide,
      output turn_req, turn_cmd, turn_pwm,
      output seek_req, seek_cmd, seek_pwm,
      input  f_IN1, f_IN2, f_IN3, f_IN4, f_enA, f_enB,
      input  turn_gnt, seek_gnt, fault_active
   );

   modport slave (
      input  enable, overide,
      input  turn_req, turn_cmd, turn_pwm,
      input  seek_req, seek_cmd, seek_pwm,
      output f_IN1, f_IN2, f_IN3, f_IN4, f_enA, f_enB,
      output turn_gnt, seek_gnt, fault_active
   );
endinterface

`default_nettype wire

// File: rtl/motor_arbiter.sv
// ------------------------------------------------------------------
// motor_arbiter : turn/seek H-bridge arbiter with dead time and fault
// hold. MOTOR_ARBITER_BRAKE_EN brakes during dead time. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module motor_arbiter #(
   parameter int DEADTIME_CYCLES = 4,
   parameter int FAULT_HOLD      = 1000
) (
   input  logic            clk,
   input  logic            rst,
   motor_arbiter_if.slave  bus
);

   localparam logic [1:0]  c_ST_IDLE  = 2'd0;
   localparam logic [1:0]  c_ST_DEAD  = 2'd1;
   localparam logic [1:0]  c_ST_DRIVE = 2'd2;
   localparam logic [1:0]  c_ST_FAULT = 2'd3;

   localparam logic [1:0]  c_CMD_STOP  = 2'b00;
   localparam logic [1:0]  c_CMD_FWD   = 2'b01;
   localparam logic [1:0]  c_CMD_LEFT  = 2'b10;

   localparam logic [15:0] c_DT_LOAD = 16'(DEADTIME_CYCLES - 1);
   localparam logic [15:0] c_FH_LOAD = 16'(FAULT_HOLD - 1);

   logic [1:0]  r_state;
   logic [15:0] r_cnt;
   logic        r_tgt;        // 0 = turn, 1 = seek
   logic [1:0]  r_cmd;

   logic [1:0]  w_state_nx;
   logic [15:0] w_cnt_nx;
   logic        w_tgt_nx;
   logic [1:0]  w_cmd_nx;

   logic        w_any_req;
   logic        w_win_tgt;
   logic [1:0]  w_win_cmd;

   logic [3:0]  w_in;
   logic        w_en;
   logic        w_turn_gnt;
   logic        w_seek_gnt;
   logic        w_fault;

   assign w_any_req = bus.turn_req | bus.seek_req;
   assign w_win_tgt = ~bus.turn_req;
   assign w_win_cmd = bus.turn_req ? bus.turn_cmd : bus.seek_cmd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= '0;
         r_tgt   <= 1'b0;
         r_cmd   <= c_CMD_STOP;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_tgt   <= w_tgt_nx;
         r_cmd   <= w_cmd_nx;
      end
   end

   // Overcurrent beats everything; a winner change re-enters dead time at once.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_tgt_nx   = r_tgt;
      w_cmd_nx   = r_cmd;
      if (bus.overide) begin
         w_state_nx = c_ST_FAULT;
         w_cnt_nx   = c_FH_LOAD;
      end else if (r_state == c_ST_FAULT) begin
         if (r_cnt == '0) begin
            w_state_nx = c_ST_IDLE;
         end else begin
            w_cnt_nx = r_cnt - 16'd1;
         end
      end else if (!bus.enable || !w_any_req) begin
         w_state_nx = c_ST_IDLE;
         w_cnt_nx   = '0;
      end else if ((r_state == c_ST_IDLE) || (w_win_tgt != r_tgt) ||
                   (w_win_cmd != r_cmd)) begin
         w_state_nx = c_ST_DEAD;
         w_cnt_nx   = c_DT_LOAD;
         w_tgt_nx   = w_win_tgt;
         w_cmd_nx   = w_win_cmd;
      end else if (r_state == c_ST_DEAD) begin
         if (r_cnt == '0) begin
            w_state_nx = c_ST_DRIVE;
         end else begin
            w_cnt_nx = r_cnt - 16'd1;
         end
      end
   end

   always_comb begin
      w_in       = 4'b0000;
      w_en       = 1'b0;
      w_turn_gnt = 1'b0;
      w_seek_gnt = 1'b0;
      w_fault    = 1'b0;
      case (r_state)
         c_ST_DEAD: begin
            w_turn_gnt = ~r_tgt;
            w_seek_gnt = r_tgt;
`ifdef MOTOR_ARBITER_BRAKE_EN
            w_in       = 4'b1111;
            w_en       = 1'b1;
`else
            w_in       = 4'b0000;
            w_en       = 1'b0;
`endif
         end
         c_ST_DRIVE: begin
            w_turn_gnt = ~r_tgt;
            w_seek_gnt = r_tgt;
            case (r_cmd)
               c_CMD_STOP: w_in = 4'b0000;
               c_CMD_FWD:  w_in = 4'b1010;
               c_CMD_LEFT: w_in = 4'b0110;
               default:    w_in = 4'b1001;
            endcase
            w_en = (r_cmd != c_CMD_STOP) & (r_tgt ? bus.seek_pwm : bus.turn_pwm);
         end
         c_ST_FAULT: begin
            w_fault = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.f_IN1        = w_in[3];
   assign bus.f_IN2        = w_in[2];
   assign bus.f_IN3        = w_in[1];
   assign bus.f_IN4        = w_in[0];
   assign bus.f_enA        = w_en;
   assign bus.f_enB        = w_en;
   assign bus.turn_gnt     = w_turn_gnt;
   assign bus.seek_gnt     = w_seek_gnt;
   assign bus.fault_active = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_motor_arbiter.sv
// ------------------------------------------------------------------
// tb_motor_arbiter : directed + random bench with a cycle-level model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_motor_arbiter;

   localparam int DT = 4;
   localparam int FH = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   motor_arbiter_if bus ();

   motor_arbiter #(
      .DEADTIME_CYCLES (DT),
      .FAULT_HOLD      (FH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: who owns the motors, with which command, for how long.
   int         m_owner;   // 0 none, 1 turn, 2 seek
   logic [1:0] m_cmd;
   int         m_since;
   bit         m_fault;
   int         m_quiet;

   function automatic logic [3:0] pat(input logic [1:0] c);
      case (c)
         2'b00:   return 4'b0000;
         2'b01:   return 4'b1010;
         2'b10:   return 4'b0110;
         default: return 4'b1001;
      endcase
   endfunction

   task automatic model_update();
      int         win;
      logic [1:0] wcmd;
      if (rst) begin
         m_owner = 0; m_fault = 0; m_since = 0; m_quiet = 0; m_cmd = 2'b00;
      end else if (bus.overide) begin
         m_fault = 1; m_quiet = 0; m_owner = 0;
      end else if (m_fault) begin
         m_quiet++;
         if (m_quiet >= FH) m_fault = 0;
      end else if (!bus.enable) begin
         m_owner = 0;
      end else begin
         win  = bus.turn_req ? 1 : (bus.seek_req ? 2 : 0);
         wcmd = bus.turn_req ? bus.turn_cmd : bus.seek_cmd;
         if (win == 0) begin
            m_owner = 0;
         end else if (m_owner == win && m_cmd == wcmd) begin
            if (m_since < 1000) m_since++;
         end else begin
            m_owner = win; m_cmd = wcmd; m_since = 0;
         end
      end
   endtask

   function automatic logic [8:0] expected();
      logic [3:0] e_in = 4'b0000;
      logic       e_en = 1'b0;
      logic       tg   = 1'b0;
      logic       sg   = 1'b0;
      if (!m_fault && m_owner != 0) begin
         tg = (m_owner == 1);
         sg = (m_owner == 2);
         if (m_since >= DT) begin
            e_in = pat(m_cmd);
            e_en = (m_cmd != 2'b00) && ((m_owner == 1) ? bus.turn_pwm : bus.seek_pwm);
         end else begin
`ifdef MOTOR_ARBITER_BRAKE_EN
            e_in = 4'b1111;
            e_en = 1'b1;
`endif
         end
      end
      return {e_in, e_en, e_en, tg, sg, m_fault};
   endfunction

   function automatic logic [8:0] observed();
      return {bus.f_IN1, bus.f_IN2, bus.f_IN3, bus.f_IN4, bus.f_enA, bus.f_enB,
              bus.turn_gnt, bus.seek_gnt, bus.fault_active};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (IN1..4,enA,enB,tgnt,sgnt,fault)",
                tag, obs, exp);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      check(tag, observed(), expected());
      checks++;
      assert (!(bus.turn_gnt === 1'b1 && bus.seek_gnt === 1'b1)) else begin
         errors++;
         $error("FAIL %s_onehot observed=%b%b expected=not both 1",
                tag, bus.turn_gnt, bus.seek_gnt);
      end
   endtask

   task automatic drive(input bit en, input bit ov,
                        input bit tr, input logic [1:0] tc, input bit tp,
                        input bit sr, input logic [1:0] sc, input bit sp);
      bus.enable   = en;  bus.overide  = ov;
      bus.turn_req = tr;  bus.turn_cmd = tc;  bus.turn_pwm = tp;
      bus.seek_req = sr;  bus.seek_cmd = sc;  bus.seek_pwm = sp;
   endtask

   initial begin
      m_owner = 0; m_cmd = 2'b00; m_since = 0; m_fault = 0; m_quiet = 0;
      rst = 1'b1;
      drive(0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
      repeat (2) step("reset");
      rst = 1'b0;

      drive(1, 0, 0, 2'b00, 0, 1, 2'b01, 1);
      repeat (6) step("seek_fwd");
      bus.seek_pwm = 1'b0;
      step("seek_pwm_low");
      bus.seek_pwm = 1'b1;

      bus.turn_req = 1'b1; bus.turn_cmd = 2'b10; bus.turn_pwm = 1'b1;
      repeat (6) step("turn_preempt");

      bus.turn_cmd = 2'b00;
      repeat (6) step("turn_stop");
      bus.turn_cmd = 2'b10;
      repeat (2) step("turn_left_dead");
      bus.turn_cmd = 2'b11;
      repeat (6) step("turn_cmd_change");

      bus.overide = 1'b1;
      repeat (3) step("fault_enter");
      bus.overide = 1'b0;
      repeat (4) step("fault_hold");
      bus.overide = 1'b1;
      step("fault_pulse");
      bus.overide = 1'b0;
      repeat (14) step("fault_exit");

      bus.enable = 1'b0;
      repeat (2) step("enable_low");
      bus.enable = 1'b1;
      repeat (2) step("reenter_dead");
      rst = 1'b1;
      step("rst_mid_dead");
      rst = 1'b0;
      bus.turn_req = 1'b0;
      bus.seek_req = 1'b0;
      repeat (2) step("idle");
      bus.turn_req = 1'b1; bus.seek_req = 1'b1;
      repeat (6) step("same_cycle");
      rst = 1'b1;
      step("rst_over_drive");
      rst = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         rst          = ($urandom_range(0, 149) == 0);
         bus.overide  = ($urandom_range(0, 49) == 0);
         bus.enable   = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 5) == 0) bus.turn_req = ~bus.turn_req;
         if ($urandom_range(0, 5) == 0) bus.seek_req = ~bus.seek_req;
         if ($urandom_range(0, 7) == 0) bus.turn_cmd = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) bus.seek_cmd = 2'($urandom_range(0, 3));
         bus.turn_pwm = 1'($urandom_range(0, 1));
         bus.seek_pwm = 1'($urandom_range(0, 1));
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
